// File: rtl/uart_tx_stream.sv
// uart_tx_stream: buffered UART transmitter.
// Words enter through a valid/ready handshake into a small circular FIFO and
// leave on `tx` as DATA_WIDTH/8 UART frames, least significant byte first,
// LSB-first within each byte, with optional parity and one or two stop bits.
// Bit timing comes entirely from the external baud tick `clken`.

module uart_tx_stream #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               clken,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [DATA_WIDTH-1:0]              data_in,
    output logic                               tx,
    output logic                               tx_busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);

    // ------------------------------------------------------------------
    // Derived sizes and constants
    // ------------------------------------------------------------------
    localparam int NBYTES  = DATA_WIDTH / 8;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int BIDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    localparam logic [PTR_W:0]    PTR_ONE   = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [BIDX_W-1:0] BIDX_ONE  = BIDX_W'(1'b1);
    localparam logic [BIDX_W-1:0] BIDX_LAST = BIDX_W'(NBYTES - 1);
    localparam logic              ODD_SEL   = (PARITY_ODD != 0) ? 1'b1 : 1'b0;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------

    // Parity bit for one data byte; odd=1 makes the total count of ones odd.
    function automatic logic parity_bit(input logic [7:0] data_byte, input logic odd);
        return (^data_byte) ^ odd;
    endfunction

    // Occupancy of a circular buffer whose pointers carry one extra wrap bit.
    function automatic logic [PTR_W:0] ptr_distance(input logic [PTR_W:0] wr,
                                                    input logic [PTR_W:0] rd);
        return wr - rd;
    endfunction

    // ------------------------------------------------------------------
    // Serialiser state encoding
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } ser_state_t;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem_r [FIFO_DEPTH];
    logic [PTR_W:0]        wr_ptr_r;
    logic [PTR_W:0]        rd_ptr_r;

    ser_state_t            state_r;
    logic [DATA_WIDTH-1:0] shreg_r;
    logic [BIDX_W-1:0]     byte_idx_r;
    logic [2:0]            bit_idx_r;
    logic                  stop_cnt_r;
    logic                  tx_r;

    // ------------------------------------------------------------------
    // Combinational status derived from registers only
    // ------------------------------------------------------------------
    logic                  full_s;
    logic                  empty_s;
    logic                  push_s;
    logic                  pop_s;
    logic [PTR_W:0]        count_s;
    logic [7:0]            cur_byte_s;
    logic                  last_stop_s;
    logic                  last_byte_s;

    // FIFO flags: same index with differing wrap bits means full, identical pointers mean empty.
    always_comb begin
        full_s  = 1'b0;
        empty_s = 1'b0;
        if (wr_ptr_r == rd_ptr_r) begin
            empty_s = 1'b1;
        end else if ((wr_ptr_r[PTR_W] != rd_ptr_r[PTR_W]) &&
                     (wr_ptr_r[PTR_W-1:0] == rd_ptr_r[PTR_W-1:0])) begin
            full_s = 1'b1;
        end else begin
            full_s  = 1'b0;
            empty_s = 1'b0;
        end
    end

    // Handshake and serialiser decode terms.
    always_comb begin
        count_s     = ptr_distance(wr_ptr_r, rd_ptr_r);
        push_s      = in_valid && !full_s;
        pop_s       = (state_r == ST_IDLE) && !empty_s;
        cur_byte_s  = shreg_r[7:0];
        last_byte_s = (byte_idx_r == BIDX_LAST);
        if (STOP_BITS == 1) begin
            last_stop_s = 1'b1;
        end else begin
            last_stop_s = stop_cnt_r;
        end
    end

    assign in_ready   = !full_s;
    assign tx_busy    = (state_r != ST_IDLE) || !empty_s;
    assign fifo_count = CNT_W'(count_s);
    assign tx         = tx_r;

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------

    // Word storage: written at the write pointer on an accepted push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r[PTR_W-1:0]] <= data_in;
        end
    end

    // Circular pointers; a push and a pop in the same cycle leave the occupancy unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Serialiser
    // ------------------------------------------------------------------

    // Frame sequencer: IDLE pops without waiting for a tick, every other state moves only on clken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            shreg_r    <= '0;
            byte_idx_r <= '0;
            bit_idx_r  <= 3'd0;
            stop_cnt_r <= 1'b0;
            tx_r       <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    tx_r <= 1'b1;
                    if (pop_s) begin
                        shreg_r    <= mem_r[rd_ptr_r[PTR_W-1:0]];
                        byte_idx_r <= '0;
                        stop_cnt_r <= 1'b0;
                        state_r    <= ST_START;
                    end
                end

                ST_START: begin
                    if (clken) begin
                        tx_r      <= 1'b0;
                        bit_idx_r <= 3'd0;
                        state_r   <= ST_DATA;
                    end
                end

                ST_DATA: begin
                    if (clken) begin
                        tx_r      <= cur_byte_s[bit_idx_r];
                        bit_idx_r <= bit_idx_r + 3'd1;
                        if (bit_idx_r == 3'd7) begin
                            state_r <= (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                        end
                    end
                end

                ST_PARITY: begin
                    if (clken) begin
                        tx_r    <= parity_bit(cur_byte_s, ODD_SEL);
                        state_r <= ST_STOP;
                    end
                end

                ST_STOP: begin
                    if (clken) begin
                        tx_r <= 1'b1;
                        if (last_stop_s) begin
                            stop_cnt_r <= 1'b0;
                            if (!last_byte_s) begin
                                // Next byte of the same word: bring it down to the low lane.
                                byte_idx_r <= byte_idx_r + BIDX_ONE;
                                shreg_r    <= shreg_r >> 4'd8;
                                state_r    <= ST_START;
                            end else begin
                                state_r <= ST_IDLE;
                            end
                        end else begin
                            stop_cnt_r <= stop_cnt_r + 1'b1;
                        end
                    end
                end

                default: begin
                    state_r    <= ST_IDLE;
                    stop_cnt_r <= 1'b0;
                    tx_r       <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_stream.sv
// Bench for uart_tx_stream: four configurations share clock, baud tick and
// reset. A recorder captures each `tx` level after every baud tick; a
// behavioural UART receiver decodes those levels and compares the bytes
// against the words the bench saw accepted.
`timescale 1ns/1ps

module tb_uart_tx_stream;

    localparam int NI = 4;

    // Per-instance configuration: bytes per word, parity enable, odd parity, stop bits.
    int nbytes_c [NI] = '{4, 1, 1, 2};
    int pe_c     [NI] = '{0, 1, 1, 0};
    int odd_c    [NI] = '{0, 0, 1, 0};
    int sb_c     [NI] = '{1, 1, 1, 2};

    logic        clk = 1'b0;
    logic        rst;
    logic        clken;
    logic        in_valid_v   [NI];
    logic        in_ready_v   [NI];
    logic        tx_v         [NI];
    logic        tx_busy_v    [NI];
    logic [2:0]  fifo_count_v [NI];
    logic [1:0]  fc2;
    logic [31:0] data0;
    logic [7:0]  data1;
    logic [7:0]  data2;
    logic [15:0] data3;

    assign fifo_count_v[2] = {1'b0, fc2};

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    int   clken_period = 0;

    logic       rec_q [NI][$];
    logic [7:0] exp_q [NI][$];

    uart_tx_stream u_dut0 (
        .clk(clk), .rst(rst), .clken(clken), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
        .data_in(data0), .tx(tx_v[0]), .tx_busy(tx_busy_v[0]), .fifo_count(fifo_count_v[0]));

    uart_tx_stream #(.DATA_WIDTH(8), .PARITY_EN(1), .PARITY_ODD(0)) u_dut1 (
        .clk(clk), .rst(rst), .clken(clken), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
        .data_in(data1), .tx(tx_v[1]), .tx_busy(tx_busy_v[1]), .fifo_count(fifo_count_v[1]));

    uart_tx_stream #(.DATA_WIDTH(8), .FIFO_DEPTH(2), .PARITY_EN(1), .PARITY_ODD(1)) u_dut2 (
        .clk(clk), .rst(rst), .clken(clken), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
        .data_in(data2), .tx(tx_v[2]), .tx_busy(tx_busy_v[2]), .fifo_count(fc2));

    uart_tx_stream #(.DATA_WIDTH(16), .STOP_BITS(2)) u_dut3 (
        .clk(clk), .rst(rst), .clken(clken), .in_valid(in_valid_v[3]), .in_ready(in_ready_v[3]),
        .data_in(data3), .tx(tx_v[3]), .tx_busy(tx_busy_v[3]), .fifo_count(fifo_count_v[3]));

    // Free-running system clock.
    initial forever #5 clk = ~clk;

    // Baud tick generator and line recorder, both on the falling edge.
    initial begin
        int div;
        div   = 0;
        clken = 1'b0;
        forever begin
            @(negedge clk);
            if (clken) begin
                for (int k = 0; k < NI; k++) rec_q[k].push_back(tx_v[k]);
            end
            if (clken_period < 1) begin
                clken = 1'b0;
                div   = 0;
            end else if (div >= clken_period - 1) begin
                clken = 1'b1;
                div   = 0;
            end else begin
                clken = 1'b0;
                div++;
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: inputs and outputs are handled 2 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #2;
        cyc++;
    endtask

    task automatic set_data(input int k, input logic [31:0] w);
        case (k)
            0:       data0 = w;
            1:       data1 = w[7:0];
            2:       data2 = w[7:0];
            default: data3 = w[15:0];
        endcase
    endtask

    task automatic add_expect(input int k, input logic [31:0] w);
        logic [31:0] t;
        t = w;
        for (int b = 0; b < nbytes_c[k]; b++) begin
            exp_q[k].push_back(t[7:0]);
            t = t >> 8;
        end
    endtask

    task automatic clear_all();
        for (int k = 0; k < NI; k++) begin
            rec_q[k].delete();
            exp_q[k].delete();
        end
    endtask

    task automatic push_word(input int k, input logic [31:0] w);
        bit acc;
        acc = 1'b0;
        set_data(k, w);
        in_valid_v[k] = 1'b1;
        for (int t = 0; t < 3000 && !acc; t++) begin
            acc = (in_ready_v[k] === 1'b1);
            step();
        end
        in_valid_v[k] = 1'b0;
        check_val("push_accepted", 32'(acc), 32'd1);
        if (acc) add_expect(k, w);
    endtask

    task automatic wait_drain(input string tag);
        bit busy;
        busy = 1'b1;
        for (int t = 0; t < 30000 && busy; t++) begin
            step();
            busy = tx_busy_v[0] | tx_busy_v[1] | tx_busy_v[2] | tx_busy_v[3];
        end
        check_val({tag, "_drained"}, 32'(busy), 32'd0);
        repeat (3 * clken_period + 4) step();
    endtask

    // Behavioural receiver: a 0 level after a tick opens a frame of fixed length.
    task automatic decode(input int k, input bit contig, input string tag);
        int fl, i, prev, bad_stop, bad_par, gaps;
        logic [7:0] b;
        logic [7:0] got_q [$];
        fl = 9 + pe_c[k] + sb_c[k];
        i = 0; prev = -1; bad_stop = 0; bad_par = 0; gaps = 0;
        while (i < rec_q[k].size()) begin
            if (rec_q[k][i] === 1'b0) begin
                if (i + fl > rec_q[k].size()) begin
                    bad_stop++;
                    break;
                end
                for (int j = 0; j < 8; j++) b[j] = rec_q[k][i + 1 + j];
                if (pe_c[k] != 0 && rec_q[k][i + 9] !== ((^b) ^ odd_c[k][0])) bad_par++;
                for (int s = 0; s < sb_c[k]; s++)
                    if (rec_q[k][i + 9 + pe_c[k] + s] !== 1'b1) bad_stop++;
                if (contig && prev >= 0 && (i - prev) != fl) gaps++;
                prev = i;
                got_q.push_back(b);
                i += fl;
            end else begin
                i++;
            end
        end
        check_val({tag, "_nframes"}, 32'(got_q.size()), 32'(exp_q[k].size()));
        for (int j = 0; j < got_q.size() && j < exp_q[k].size(); j++)
            check_val({tag, "_byte"}, 32'(got_q[j]), 32'(exp_q[k][j]));
        check_val({tag, "_stop"}, 32'(bad_stop), 32'd0);
        if (pe_c[k] != 0) check_val({tag, "_parity"}, 32'(bad_par), 32'd0);
        if (contig) check_val({tag, "_gap"}, 32'(gaps), 32'd0);
    endtask

    // Levels of the first frame on the line, bit j = j-th level after the start.
    task automatic frame_levels(input int k, input int n, output logic [31:0] lv);
        int idx;
        idx = -1;
        lv  = 'x;
        for (int i = 0; i < rec_q[k].size(); i++) begin
            if (rec_q[k][i] === 1'b0) begin
                idx = i;
                break;
            end
        end
        if (idx >= 0 && idx + n <= rec_q[k].size()) begin
            lv = '0;
            for (int j = 0; j < n; j++) lv[j] = rec_q[k][idx + j];
        end
    endtask

    initial begin
        logic [31:0] w, lv;
        logic [31:0] fill_w [6];
        logic [31:0] cur_w  [NI];
        logic        exp_bits [$];
        int          push_cyc, tick, m_cnt, j, idx, zeros;
        bit          m_busy, acc, pop;
        bit          acc_v [NI];

        rst = 1'b1;
        for (int k = 0; k < NI; k++) in_valid_v[k] = 1'b0;
        data0 = '0; data1 = '0; data2 = '0; data3 = '0;

        // Reset values.
        repeat (3) step();
        for (int k = 0; k < NI; k++) begin
            check_val("rst_tx", 32'(tx_v[k]), 32'd1);
            check_val("rst_in_ready", 32'(in_ready_v[k]), 32'd1);
            check_val("rst_tx_busy", 32'(tx_busy_v[k]), 32'd0);
            check_val("rst_fifo_count", 32'(fifo_count_v[k]), 32'd0);
        end
        rst = 1'b0;
        step();

        // Default config, one word, tick every 16 cycles: latency, 40 levels, busy window.
        clken_period = 16;
        clear_all();
        w = 32'hA5C30F81;
        for (int b = 0; b < 4; b++) begin
            exp_bits.push_back(1'b0);
            for (int q = 0; q < 8; q++) exp_bits.push_back(w[8 * b + q]);
            exp_bits.push_back(1'b1);
        end
        push_word(0, w);
        push_cyc = cyc;
        tick = 0;
        for (int t = 0; t < 3000 && tick < 40; t++) begin
            step();
            if (clken) begin
                if (cyc < push_cyc + 2) begin
                    check_val("a_early_idle", 32'(tx_v[0]), 32'd1);
                end else begin
                    check_val("a_level", 32'(tx_v[0]), 32'(exp_bits[tick]));
                    check_val("a_busy", 32'(tx_busy_v[0]), 32'((tick < 39) ? 1 : 0));
                    tick++;
                end
            end
        end
        check_val("a_ticks", 32'(tick), 32'd40);
        wait_drain("a");

        // Parity even/odd on 8-bit words and a 16-bit word with two stop bits.
        clken_period = 4;
        clear_all();
        push_word(1, 32'h07);
        push_word(2, 32'h07);
        push_word(3, 32'h1234);
        wait_drain("b");
        frame_levels(1, 11, lv);
        check_val("b_even_frame", lv, 32'h0000_060E);
        frame_levels(2, 11, lv);
        check_val("b_odd_frame", lv, 32'h0000_040E);
        decode(1, 1'b0, "b_even");
        decode(2, 1'b0, "b_odd");
        decode(3, 1'b1, "b_w16");

        // Tick held low: fill the FIFO one word per cycle and watch occupancy.
        clken_period = 0;
        step();
        clear_all();
        for (int i = 0; i < 6; i++) fill_w[i] = $urandom;
        m_cnt = 0; m_busy = 1'b0; j = 0;
        for (int t = 0; t < 10; t++) begin
            if (j < 6) begin
                set_data(0, fill_w[j]);
                in_valid_v[0] = 1'b1;
            end else begin
                in_valid_v[0] = 1'b0;
            end
            acc = (j < 6) && (m_cnt < 4);
            pop = !m_busy && (m_cnt > 0);
            step();
            if (pop) begin
                m_cnt--;
                m_busy = 1'b1;
            end
            if (acc) begin
                m_cnt++;
                add_expect(0, fill_w[j]);
                j++;
            end
            check_val("f_count", 32'(fifo_count_v[0]), 32'(m_cnt));
            check_val("f_in_ready", 32'(in_ready_v[0]), 32'((m_cnt < 4) ? 1 : 0));
            check_val("f_busy", 32'(tx_busy_v[0]), 32'((m_busy || m_cnt > 0) ? 1 : 0));
        end
        check_val("f_held_words", 32'(j), 32'd5);
        clken_period = 3;
        push_word(0, fill_w[5]);
        wait_drain("f");
        decode(0, 1'b1, "f_stream");

        // Random words, random push timing, random tick spacing.
        for (int r = 0; r < 3; r++) begin
            clken_period = $urandom_range(2, 7);
            clear_all();
            for (int t = 0; t < 300; t++) begin
                for (int k = 0; k < NI; k++) begin
                    if (in_valid_v[k] == 1'b0 && $urandom_range(0, 3) == 0) begin
                        cur_w[k] = $urandom;
                        set_data(k, cur_w[k]);
                        in_valid_v[k] = 1'b1;
                    end
                    acc_v[k] = in_valid_v[k] && in_ready_v[k];
                end
                step();
                for (int k = 0; k < NI; k++) begin
                    if (acc_v[k]) begin
                        add_expect(k, cur_w[k]);
                        in_valid_v[k] = 1'b0;
                    end
                end
            end
            for (int k = 0; k < NI; k++) in_valid_v[k] = 1'b0;
            wait_drain("r");
            for (int k = 0; k < NI; k++) decode(k, 1'b0, "r_rand");
        end

        // Reset in the middle of the second byte with another word queued.
        clken_period = 4;
        clear_all();
        push_word(0, 32'h1234_00FF);
        push_word(0, $urandom);
        idx = -1;
        for (int t = 0; t < 2000; t++) begin
            step();
            if (idx < 0) begin
                for (int i = 0; i < rec_q[0].size(); i++) begin
                    if (rec_q[0][i] === 1'b0) begin
                        idx = i;
                        break;
                    end
                end
            end
            if (idx >= 0 && rec_q[0].size() >= idx + 14) break;
        end
        check_val("x_pre_tx", 32'(tx_v[0]), 32'd0);
        check_val("x_pre_count", 32'(fifo_count_v[0]), 32'd1);
        rst = 1'b1;
        #1;
        check_val("x_async_tx", 32'(tx_v[0]), 32'd1);
        check_val("x_count", 32'(fifo_count_v[0]), 32'd0);
        check_val("x_busy", 32'(tx_busy_v[0]), 32'd0);
        check_val("x_in_ready", 32'(in_ready_v[0]), 32'd1);
        step();
        step();
        rst = 1'b0;
        clear_all();
        repeat (120) step();
        zeros = 0;
        for (int i = 0; i < rec_q[0].size(); i++) if (rec_q[0][i] !== 1'b1) zeros++;
        check_val("x_line_quiet", 32'(zeros), 32'd0);
        check_val("x_ticks_seen", 32'((rec_q[0].size() >= 20) ? 1 : 0), 32'd1);
        check_val("x_post_busy", 32'(tx_busy_v[0]), 32'd0);
        check_val("x_post_count", 32'(fifo_count_v[0]), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
